cache_mem_responder: RTL and testbench

- Memory-side responder for the cache-to-memory word interface (cs / writeMemoryEnable / memory_addr / memory_data / ack / fetchdata).
- Serves one 32-bit word per request from an internal word array, with programmable access latency.
- Returns a one-cycle ack pulse per word, so line fills (8 reads) and write-backs (8 writes) complete word by word.
- Sits between the cache and, in simulation/FPGA builds, stands in as main memory.

---
 rtl/cache_mem_responder.sv | 136 +++++++++++++
 tb/tb_cache_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side word responder for the cache: one 32-bit word per request,
// with a programmable access latency and a one-cycle ack pulse per word.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clock,
    input  logic        cpu_rst_n,
    input  logic        cs,
    input  logic        writeMemoryEnable,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_data,
    output logic        ack,
    output logic [31:0] fetchdata,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_lat_cnt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic                    r_we;
    logic                    r_ack;
    logic [31:0]             r_fetchdata;
    logic                    r_busy;
    logic [15:0]             r_rd_count;
    logic [15:0]             r_wr_count;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_capture;
    logic                    w_done;
    logic                    w_ram_we;
    logic [ADDR_WIDTH-1:0]   w_addr_idx;
    logic                    w_unused_addr_bits;

    assign w_addr_idx         = memory_addr[ADDR_WIDTH+1:2];
    assign w_unused_addr_bits = ^{memory_addr[31:ADDR_WIDTH+2], memory_addr[1:0]};

    assign w_capture = (r_state == S_IDLE) && cs;
    assign w_done    = (r_state == S_BUSY) && (r_lat_cnt == 4'd0);
    assign w_ram_we  = w_done && r_we;

    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cs) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_lat_cnt == 4'd0) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture; bus inputs are only looked at in IDLE.
    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_capture) begin
            r_idx   <= w_addr_idx;
            r_wdata <= memory_data;
            r_we    <= writeMemoryEnable;
        end
    end

    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_lat_cnt <= '0;
        end else if (w_capture) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == S_BUSY) && (r_lat_cnt != 4'd0)) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_fetchdata <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_ack <= w_done;
            if (w_capture) begin
                r_busy <= 1'b1;
            end else if (r_state == S_HOLD) begin
                r_busy <= 1'b0;
            end
            if (w_done) begin
                if (r_we) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    r_fetchdata <= r_mem[r_idx];
                    r_rd_count  <= r_rd_count + 16'd1;
                end
            end
        end
    end

    // Array has no reset; an access abandoned by reset never reaches w_done.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign fetchdata = r_fetchdata;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: single, burst, alias, mid-access
// input change and mid-access reset scenarios with hand-computed results.
module tb_cache_mem_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int LATENCY    = 3;

    logic        clock;
    logic        cpu_rst_n;
    logic        cs;
    logic        writeMemoryEnable;
    logic [31:0] memory_addr;
    logic [31:0] memory_data;
    logic        ack;
    logic [31:0] fetchdata;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rd  = 0;
    int exp_wr  = 0;

    cache_mem_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clock            (clock),
        .cpu_rst_n        (cpu_rst_n),
        .cs               (cs),
        .writeMemoryEnable(writeMemoryEnable),
        .memory_addr      (memory_addr),
        .memory_data      (memory_data),
        .ack              (ack),
        .fetchdata        (fetchdata),
        .busy             (busy),
        .rd_count         (rd_count),
        .wr_count         (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Counts edges until ack is seen at a falling edge; -1 on timeout.
    task automatic wait_ack(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (ack) begin
                n = k;
                break;
            end
        end
    endtask

    // Single access, starting and ending at a falling edge with DUT idle.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic corrupt,
                          input logic chk_rdata, input logic [31:0] exp_rdata);
        int n;
        cs = 1'b1; writeMemoryEnable = we; memory_addr = addr; memory_data = data;
        @(posedge clock);
        @(negedge clock);
        cs = 1'b0;
        if (corrupt) begin
            memory_data = 32'h0;
            writeMemoryEnable = 1'b0;
            memory_addr = 32'hFFFF_FFFC;
        end
        wait_ack(n);
        chk({tag, "_latency"}, 32'(n), 32'(LATENCY));
        if (we) exp_wr++; else exp_rd++;
        if (chk_rdata) chk({tag, "_rdata"}, fetchdata, exp_rdata);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(exp_wr));
        chk({tag, "_rd_count"}, 32'(rd_count), 32'(exp_rd));
        cyc();
        chk({tag, "_ack_single"}, 32'(ack), 32'd0);
        cyc();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        cpu_rst_n = 1'b0; cs = 1'b0; writeMemoryEnable = 1'b0;
        memory_addr = '0; memory_data = '0;
        repeat (3) cyc();
        cpu_rst_n = 1'b1;
        repeat (10) cyc();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fetchdata", fetchdata, 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);

        access("wr_single", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        access("rd_single", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Burst writes with cs held high; address advances after each ack.
        cs = 1'b1; writeMemoryEnable = 1'b1;
        memory_addr = 32'h80; memory_data = 32'h100;
        for (int i = 0; i < 8; i++) begin
            wait_ack(n);
            exp_wr++;
            if (i == 0) chk("bw_first_gap", 32'(n), 32'(LATENCY + 1));
            else        chk("bw_gap", 32'(n + 1), 32'(LATENCY + 3));
            cyc();
            memory_addr = 32'h80 + 32'(4 * (i + 1));
            memory_data = 32'h100 + 32'(i + 1);
            if (i == 7) cs = 1'b0;
        end
        cyc();
        chk("bw_idle", 32'(busy), 32'd0);
        chk("bw_wr_count", 32'(wr_count), 32'(exp_wr));

        // Burst read-back.
        cs = 1'b1; writeMemoryEnable = 1'b0; memory_addr = 32'h80; memory_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            wait_ack(n);
            exp_rd++;
            if (i == 0) chk("br_first_gap", 32'(n), 32'(LATENCY + 1));
            else        chk("br_gap", 32'(n + 1), 32'(LATENCY + 3));
            chk("br_data", fetchdata, 32'h100 + 32'(i));
            cyc();
            chk("br_ack_single", 32'(ack), 32'd0);
            memory_addr = 32'h80 + 32'(4 * (i + 1));
            if (i == 7) cs = 1'b0;
        end
        cyc();
        chk("br_rd_count", 32'(rd_count), 32'(exp_rd));

        access("alias_wr", 1'b1, 32'h0000_0004, 32'h11, 1'b0, 1'b0, 32'h0);
        access("alias_rd", 1'b0, 32'h0000_1007, 32'h0, 1'b0, 1'b1, 32'h11);

        access("mid_wr", 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0);
        chk("mid_fetch_hold", fetchdata, 32'h11);
        access("mid_rd", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5);

        access("pre_wr", 1'b1, 32'h0000_0030, 32'h77, 1'b0, 1'b0, 32'h0);

        // Reset pulse during BUSY of a write to 0x30.
        cs = 1'b1; writeMemoryEnable = 1'b1; memory_addr = 32'h30; memory_data = 32'h55;
        @(posedge clock);
        @(negedge clock);
        cs = 1'b0;
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        @(posedge clock);
        #2 cpu_rst_n = 1'b0;
        #2 cpu_rst_n = 1'b1;
        exp_rd = 0; exp_wr = 0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (ack) n++;
            if (busy) n++;
        end
        chk("rstmid_no_ack_busy", 32'(n), 32'd0);
        chk("rstmid_wr_count", 32'(wr_count), 32'd0);
        chk("rstmid_fetchdata", fetchdata, 32'd0);
        access("rstmid_rd", 1'b0, 32'h0000_0030, 32'h0, 1'b0, 1'b1, 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
